// File: rtl/cpu_storebuffer_drain.sv
// Store-buffer drain stage: pops committed stores and issues masked cache writes.
// Optional DRAIN_COALESCE_EN merges consecutive same-tag stores before issue.
`ifndef WORD_WIDTH
`define WORD_WIDTH 32
`endif
`ifndef BYTE_WIDTH
`define BYTE_WIDTH 8
`endif

module cpu_storebuffer_drain #(
  parameter int TAG_WIDTH    = 16,
  parameter int DATA_WIDTH   = `WORD_WIDTH,
  parameter int STARVE_LIMIT = 8,
  parameter int MAX_MERGE    = 4,
  localparam int BYTES       = DATA_WIDTH / `BYTE_WIDTH
) (
  input  logic                  clock,
  input  logic                  reset,
  input  logic                  sb_empty,
  input  logic                  sb_full,
  input  logic [TAG_WIDTH-1:0]  sb_tag,
  input  logic [DATA_WIDTH-1:0] sb_data,
  input  logic [BYTES-1:0]      sb_mask,
  output logic                  sb_pop,
  input  logic                  port_busy,
  input  logic                  flush,
  output logic                  flush_done,
  output logic                  drain_priority,
  output logic                  wr_valid,
  input  logic                  wr_ready,
  output logic [TAG_WIDTH-1:0]  wr_tag,
  output logic [DATA_WIDTH-1:0] wr_data,
  output logic [BYTES-1:0]      wr_mask,
  output logic                  idle,
  output logic [1:0]            state_dbg
);

  // Write port: a request transfers on any cycle with wr_valid & wr_ready; while
  // wr_valid is high and wr_ready low, wr_tag/wr_data/wr_mask hold unchanged.
  localparam int BW  = `BYTE_WIDTH;
  localparam int SCW = $clog2(STARVE_LIMIT + 1);
  localparam logic [SCW-1:0] STARVE_MAX = SCW'(STARVE_LIMIT);

  localparam logic [1:0] IDLE  = 2'd0;
  localparam logic [1:0] ISSUE = 2'd1;

  if (STARVE_LIMIT < 1 || MAX_MERGE < 1) begin : g_bad_param
    $error("cpu_storebuffer_drain: STARVE_LIMIT and MAX_MERGE must be >= 1");
  end

  logic [1:0]     state, state_nxt;
  logic [SCW-1:0] starve_cnt;
  logic           grant, capture, handshake, merge_pop, load_new;

  assign drain_priority = sb_full | flush | (starve_cnt == STARVE_MAX);
  assign grant          = !port_busy | drain_priority;
  assign wr_valid       = (state == ISSUE);
  assign handshake      = wr_valid & wr_ready;
  assign capture        = !sb_empty & grant &
                          ((state == IDLE) | ((state == ISSUE) & wr_ready));
  assign load_new       = capture & (sb_mask != '0);
  assign sb_pop         = capture | merge_pop;
  assign idle           = (state == IDLE);
  assign flush_done     = flush & sb_empty & (state == IDLE);
  assign state_dbg      = state;

`ifdef DRAIN_COALESCE_EN
  localparam logic [1:0] MERGE = 2'd2;
  localparam logic [1:0] FILL  = MERGE;
  localparam int MCW = $clog2(MAX_MERGE + 1);
  logic [MCW-1:0] merge_cnt;

  assign merge_pop = (state == MERGE) & !sb_empty & grant & (sb_tag == wr_tag) &
                     (merge_cnt < MCW'(MAX_MERGE));

  // Zero-mask same-tag entries are consumed but do not use up a merge slot.
  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      merge_cnt <= '0;
    end else if (load_new) begin
      merge_cnt <= MCW'(1);
    end else if (merge_pop && sb_mask != '0) begin
      merge_cnt <= merge_cnt + MCW'(1);
    end
  end
`else
  localparam logic [1:0] FILL = ISSUE;
  assign merge_pop = 1'b0;
`endif

  always_comb begin
    state_nxt = state;
    case (state)
      IDLE:  if (capture) state_nxt = load_new ? FILL : IDLE;
      ISSUE: if (handshake) state_nxt = load_new ? FILL : IDLE;
`ifdef DRAIN_COALESCE_EN
      MERGE: if (!merge_pop) state_nxt = ISSUE;
`endif
      default: state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      state <= IDLE;
    end else begin
      state <= state_nxt;
    end
  end

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      starve_cnt <= '0;
    end else if (sb_empty || capture) begin
      starve_cnt <= '0;
    end else if (port_busy && starve_cnt != STARVE_MAX) begin
      starve_cnt <= starve_cnt + SCW'(1);
    end
  end

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      wr_tag  <= '0;
      wr_data <= '0;
      wr_mask <= '0;
    end else if (load_new) begin
      wr_tag  <= sb_tag;
      wr_data <= sb_data;
      wr_mask <= sb_mask;
    end
`ifdef DRAIN_COALESCE_EN
    else if (merge_pop) begin
      for (int i = 0; i < BYTES; i++) begin
        if (sb_mask[i]) wr_data[i*BW +: BW] <= sb_data[i*BW +: BW];
      end
      wr_mask <= wr_mask | sb_mask;
    end
`endif
  end

endmodule

// File: tb/tb_cpu_storebuffer_drain.sv
// Bench for cpu_storebuffer_drain: store-buffer model, write scoreboard, directed
// steps then randomized traffic. Honors DRAIN_COALESCE_EN for the merge case.
module tb_cpu_storebuffer_drain;
  localparam int TW = 16;
  localparam int DW = 32;
  localparam int BY = 4;
  localparam int SL = 4;
  localparam int EW = TW + DW + BY;

  typedef struct packed {
    logic [TW-1:0] tag;
    logic [DW-1:0] data;
    logic [BY-1:0] mask;
  } entry_t;

  logic          clock = 1'b0;
  logic          reset = 1'b1;
  logic          sb_empty, sb_full, sb_pop;
  logic [TW-1:0] sb_tag;
  logic [DW-1:0] sb_data;
  logic [BY-1:0] sb_mask;
  logic          port_busy = 1'b0, flush = 1'b0, wr_ready = 1'b1;
  logic          flush_done, drain_priority, wr_valid, idle;
  logic [TW-1:0] wr_tag;
  logic [DW-1:0] wr_data;
  logic [BY-1:0] wr_mask;
  logic [1:0]    state_dbg;

  entry_t        sbq[$];
  logic [EW-1:0] exp_q[$];
  int            checks = 0;
  int            failures = 0;
  bit            full_force = 1'b0;
  int            sb_depth = 99;
  bit            last_stall = 1'b0;
  logic [EW-1:0] last_wr = '0;

  cpu_storebuffer_drain #(
    .TAG_WIDTH(TW), .DATA_WIDTH(DW), .STARVE_LIMIT(SL), .MAX_MERGE(4)
  ) dut (
    .clock(clock), .reset(reset),
    .sb_empty(sb_empty), .sb_full(sb_full), .sb_tag(sb_tag), .sb_data(sb_data),
    .sb_mask(sb_mask), .sb_pop(sb_pop), .port_busy(port_busy), .flush(flush),
    .flush_done(flush_done), .drain_priority(drain_priority),
    .wr_valid(wr_valid), .wr_ready(wr_ready), .wr_tag(wr_tag), .wr_data(wr_data),
    .wr_mask(wr_mask), .idle(idle), .state_dbg(state_dbg)
  );

  // clock / reset
  always #5 clock = ~clock;

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic drive_sb();
    sb_empty = (sbq.size() == 0);
    sb_full  = full_force || (sbq.size() >= sb_depth);
    if (sbq.size() != 0) {sb_tag, sb_data, sb_mask} = sbq[0];
    else {sb_tag, sb_data, sb_mask} = '0;
  endtask

  task automatic push_entry(input logic [TW-1:0] t, input logic [DW-1:0] d,
                            input logic [BY-1:0] m, input bit expect_wr);
    entry_t e;
    e.tag = t; e.data = d; e.mask = m;
    sbq.push_back(e);
    if (expect_wr) exp_q.push_back({t, d, m});
    drive_sb();
  endtask

  // One clock: sample before the edge, advance the buffer model after it.
  task automatic tick();
    bit pop_seen;
    logic [EW-1:0] exp_w;
    @(negedge clock);
    pop_seen = sb_pop;
    if (last_stall && wr_valid) check("wr_hold_during_stall", {wr_tag, wr_data, wr_mask}, last_wr);
    if (wr_valid && wr_ready) begin
      checks++;
      assert (exp_q.size() != 0) else begin
        failures++;
        $error("FAIL unexpected_write observed=%0h expected=none", {wr_tag, wr_data, wr_mask});
      end
      if (exp_q.size() != 0) begin
        exp_w = exp_q.pop_front();
        check("write_scoreboard", {wr_tag, wr_data, wr_mask}, exp_w);
      end
    end
    if (pop_seen) begin
      checks++;
      assert (sbq.size() != 0) else begin
        failures++;
        $error("FAIL pop_on_empty observed=1 expected=0");
      end
    end
    last_stall = wr_valid && !wr_ready;
    last_wr    = {wr_tag, wr_data, wr_mask};
    @(posedge clock);
    #1;
    if (pop_seen && sbq.size() != 0) void'(sbq.pop_front());
    drive_sb();
    #1;
  endtask

  initial begin
    int tag_seq;
    int guard;
    logic [BY-1:0] m;
    drive_sb();

    // reset held two cycles
    tick(); tick();
    check("rst_wr_valid", wr_valid, 0);
    check("rst_sb_pop", sb_pop, 0);
    check("rst_idle", idle, 1);
    check("rst_prio", drain_priority, 0);
    check("rst_flush_done", flush_done, 0);
    check("rst_wr_fields", {wr_tag, wr_data, wr_mask}, 0);
    reset = 1'b0;
    tick(); tick();
    check("post_rst_idle", idle, 1);
    check("post_rst_wr_valid", wr_valid, 0);
    check("post_rst_pop", sb_pop, 0);

`ifndef DRAIN_COALESCE_EN
    // single entry
    push_entry(16'h10, 32'h11223344, 4'hF, 1'b1);
    #1;
    check("single_pop_c0", sb_pop, 1);
    check("single_valid_c0", wr_valid, 0);
    tick();
    check("single_valid_c1", wr_valid, 1);
    check("single_tag_c1", wr_tag, 16'h10);
    check("single_data_c1", wr_data, 32'h11223344);
    check("single_mask_c1", wr_mask, 4'hF);
    tick();
    check("single_valid_c2", wr_valid, 0);
    check("single_idle_c2", idle, 1);

    // backpressure, then back-to-back
    wr_ready = 1'b0;
    push_entry(16'h20, 32'hA0A0A0A0, 4'h5, 1'b1);
    push_entry(16'h21, 32'hB1B1B1B1, 4'hA, 1'b1);
    #1;
    check("bp_pop_c0", sb_pop, 1);
    tick();
    for (int i = 0; i < 3; i++) begin
      check("bp_stall_valid", wr_valid, 1);
      check("bp_stall_tag", wr_tag, 16'h20);
      check("bp_stall_data", wr_data, 32'hA0A0A0A0);
      check("bp_stall_no_pop", sb_pop, 0);
      tick();
    end
    wr_ready = 1'b1;
    #1;
    check("bp_pop_on_hs", sb_pop, 1);
    tick();
    check("bp_b2b_valid", wr_valid, 1);
    check("bp_b2b_tag", wr_tag, 16'h21);
    check("bp_b2b_mask", wr_mask, 4'hA);
    tick();
    check("bp_idle", idle, 1);

    // starvation with STARVE_LIMIT=4
    port_busy = 1'b1;
    push_entry(16'h30, 32'hC3C3C3C3, 4'hF, 1'b1);
    #1;
    for (int i = 0; i < SL; i++) begin
      check("starve_prio_low", drain_priority, 0);
      check("starve_no_pop", sb_pop, 0);
      tick();
    end
    check("starve_prio_high", drain_priority, 1);
    check("starve_pop", sb_pop, 1);
    tick();
    check("starve_issue", wr_valid, 1);
    check("starve_cnt_cleared", drain_priority, 0);
    tick();
    check("starve_idle", idle, 1);

    // flush with the load pipeline holding the port
    flush = 1'b1;
    push_entry(16'h40, 32'h40404040, 4'hF, 1'b1);
    push_entry(16'h41, 32'h41414141, 4'h3, 1'b1);
    #1;
    check("flush_prio", drain_priority, 1);
    check("flush_pop0", sb_pop, 1);
    check("flush_done_busy", flush_done, 0);
    tick();
    check("flush_tag0", wr_tag, 16'h40);
    check("flush_pop1", sb_pop, 1);
    tick();
    check("flush_tag1", wr_tag, 16'h41);
    check("flush_done_inflight", flush_done, 0);
    tick();
    check("flush_done_set", flush_done, 1);
    push_entry(16'h42, 32'hDEADBEEF, 4'h0, 1'b0);
    #1;
    check("zmask_pop", sb_pop, 1);
    check("zmask_flush_done_low", flush_done, 0);
    tick();
    check("zmask_no_valid", wr_valid, 0);
    check("zmask_idle", idle, 1);
    check("flush_done_held", flush_done, 1);
    flush = 1'b0;
    #1;
    check("flush_done_drop", flush_done, 0);
    check("flush_prio_drop", drain_priority, 0);

    // sb_full alone, then together with flush
    full_force = 1'b1;
    push_entry(16'h50, 32'h50505050, 4'h9, 1'b1);
    #1;
    check("full_prio", drain_priority, 1);
    check("full_pop", sb_pop, 1);
    tick();
    flush = 1'b1;
    #1;
    check("full_flush_prio", drain_priority, 1);
    tick();
    full_force = 1'b0;
    flush = 1'b0;
    port_busy = 1'b0;
    drive_sb();
    #1;
    check("full_idle", idle, 1);
`else
    // coalesce two same-tag halves, then a different tag
    push_entry(16'h10, 32'h00003344, 4'b0011, 1'b0);
    push_entry(16'h10, 32'h77880000, 4'b1100, 1'b0);
    exp_q.push_back({16'h10, 32'h77883344, 4'hF});
    push_entry(16'h12, 32'h00000055, 4'hF, 1'b1);
    guard = 0;
    while ((exp_q.size() != 0 || !idle) && guard < 20) begin
      tick();
      guard++;
    end
    check("merge_drained", exp_q.size(), 0);
    check("merge_idle", idle, 1);
`endif

    // randomized traffic with a 4-deep buffer
    sb_depth = 4;
    tag_seq = 16'h100;
    for (int n = 0; n < 300; n++) begin
      port_busy = ($urandom_range(0, 3) == 0);
      wr_ready  = ($urandom_range(0, 3) != 0);
      if (sbq.size() < 4 && $urandom_range(0, 1) == 1) begin
        m = BY'($urandom_range(0, 15));
        push_entry(TW'(tag_seq), $urandom, m, m != '0);
        tag_seq++;
      end
      drive_sb();
      tick();
    end
    port_busy = 1'b0;
    wr_ready  = 1'b1;
    guard = 0;
    while ((sbq.size() != 0 || !idle) && guard < 60) begin
      tick();
      guard++;
    end
    check("rand_drain_timeout", guard < 60, 1);
    check("rand_exp_empty", exp_q.size(), 0);
    check("rand_sb_empty", sbq.size(), 0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule

// File: doc/cpu_storebuffer_drain.md
Name: cpu_storebuffer_drain

Overview:
Drain stage directly downstream of the store buffer. It pops committed stores (tag, data, byte mask) from the buffer head and issues them as masked writes to the data-cache write port over a valid/ready handshake. It arbitrates the shared cache port against the load pipeline and forces priority when the buffer is full, a flush is requested, or a drain has been starved too long.

Parameters:
TAG_WIDTH, 16, width of the line tag carried with each store
DATA_WIDTH, `WORD_WIDTH, data width per entry; BYTES = DATA_WIDTH/`BYTE_WIDTH (localparam)
STARVE_LIMIT, 8, cycles a pending drain may be blocked by port_busy before forcing priority; must be >=1
MAX_MERGE, 4, maximum entries combined into one write; used only with DRAIN_COALESCE_EN

Ports:
clock  in  1  system clock, rising edge
reset  in  1  asynchronous, active-high reset
sb_empty  in  1  store buffer has no valid entry
sb_full  in  1  store buffer full
sb_tag  in  TAG_WIDTH  head entry tag
sb_data  in  DATA_WIDTH  head entry data
sb_mask  in  BYTES  head entry valid-byte mask
sb_pop  out  1  pop head; store buffer advances at this clock edge
port_busy  in  1  load pipeline owns the cache port this cycle
flush  in  1  level request: drain everything (fence/context switch)
flush_done  out  1  flush requested, buffer empty, nothing in flight
drain_priority  out  1  drain takes the cache port; load pipeline must stall
wr_valid  out  1  write request valid
wr_ready  in  1  cache accepts write
wr_tag  out  TAG_WIDTH  write tag
wr_data  out  DATA_WIDTH  write data
wr_mask  out  BYTES  write byte enables
idle  out  1  FSM in IDLE, no write outstanding

Behaviour:
- Reset (async): state=IDLE, starve_cnt=0, wr_valid=0, wr_tag/data/mask=0, sb_pop=0, drain_priority=0, flush_done=0, idle=1.
- drain_priority = sb_full | flush | (starve_cnt == STARVE_LIMIT); combinational from inputs/registers.
- grant = !port_busy | drain_priority.
- capture = !sb_empty & grant & (state==IDLE | (state==ISSUE & wr_ready)). sb_pop = capture (combinational, same cycle).
- On capture: latch sb_tag/data/mask into wr_* registers. The next state is ISSUE, or MERGE when coalescing is enabled. wr_valid rises the cycle after the pop.
- Zero-mask entry: popped, but no write is issued. State stays or returns to IDLE and wr_valid stays 0.
- ISSUE: wr_valid=1. wr_tag/data/mask are stable until the handshake (wr_valid & wr_ready).
  - On handshake with capture: load the new entry and stay in ISSUE (back-to-back writes, one per cycle).
  - On handshake without capture: go to IDLE.
  - No sb_pop while stalled on wr_ready.
- starve_cnt: increments in any cycle with !sb_empty & port_busy & !capture, saturating at STARVE_LIMIT. Clears to 0 on capture or when sb_empty.
- flush_done = flush & sb_empty & state==IDLE. It stays asserted while flush is held.
- Simultaneous sb_full and flush: identical to either alone.
- Reset mid-write drops the outstanding request. The cache and store buffer are reset by the same signal.
- idle = (state==IDLE).

Optional Feature:
DRAIN_COALESCE_EN
- Defined:
  - Capture enters MERGE.
  - In MERGE, each cycle, if !sb_empty & grant & sb_tag==wr_tag & merged_count<MAX_MERGE: pop and merge (per byte, new mask bytes overwrite data; wr_mask |= sb_mask).
  - Otherwise go to ISSUE.
  - Each MERGE cycle counts toward latency. Zero-mask same-tag entries are popped and ignored.
- Undefined: no MERGE state; capture goes directly to ISSUE; MAX_MERGE unused.

Test Plan:
1. Reset held 2 cycles -> wr_valid=0, sb_pop=0, idle=1, drain_priority=0, flush_done=0; released with sb_empty=1 -> nothing changes.
2. Single entry tag 'h10, data 'h11223344, mask 'hF, port_busy=0, wr_ready=1 -> cycle0 sb_pop=1; cycle1 wr_valid=1, wr_tag='h10, wr_data='h11223344, wr_mask='hF; cycle2 wr_valid=0, idle=1.
3. Backpressure: two entries, wr_ready=0 for 3 cycles after the first issue -> wr_* stable for 3 cycles, sb_pop=0. Second entry popped on the handshake cycle, issued the next cycle (back-to-back).
4. Starvation: STARVE_LIMIT=4, port_busy=1 constant, one entry -> drain_priority=0 for cycles 0-3, =1 at cycle 4 with sb_pop=1; starve_cnt returns to 0 afterwards.
5. Flush: 2 entries, port_busy=1, flush=1 -> drain_priority=1 immediately, both writes issued. flush_done=1 the cycle after the second handshake once sb_empty=1. A zero-mask third entry is popped with no wr_valid.
6. With DRAIN_COALESCE_EN: tag 'h10 mask 'b0011 data 'h00003344, then tag 'h10 mask 'b1100 data 'h77880000, then tag 'h12 -> one write with tag 'h10, data 'h77883344, mask 'hF; a separate write follows for 'h12.
